// File: rtl/id_pipe_pkg.sv
// Shared decode constants, immediate-format enumeration and the opcode
// classifier used by id_pipe.
package id_pipe_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic     use_rs1;
    logic     use_rs2;
    logic     illegal;
    logic     wen_cls;
    imm_fmt_e fmt;
  } dec_ctrl_t;

  // Illegal encodings read no registers, write nothing and need no immediate.
  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] inst);
    dec_ctrl_t  c;
    logic [2:0] f3;
    logic [6:0] f7;
    c   = '0;
    f3  = inst[14:12];
    f7  = inst[31:25];
    case (inst[6:0])
      OPC_OP_IMM: begin
        c.use_rs1 = 1'b1;
        c.wen_cls = 1'b1;
        c.fmt     = IMM_I;
      end
      OPC_OP: begin
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
        c.wen_cls = 1'b1;
        c.illegal = !((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
      end
      OPC_BRANCH: begin
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
        c.fmt     = IMM_B;
        c.illegal = (f3 == F3_BR_RSV0) || (f3 == F3_BR_RSV1);
      end
      OPC_LUI, OPC_AUIPC: begin
        c.wen_cls = 1'b1;
        c.fmt     = IMM_U;
      end
      OPC_JAL: begin
        c.wen_cls = 1'b1;
        c.fmt     = IMM_J;
      end
      OPC_JALR, OPC_LOAD: begin
        c.use_rs1 = 1'b1;
        c.wen_cls = 1'b1;
        c.fmt     = IMM_I;
      end
      OPC_STORE: begin
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
        c.fmt     = IMM_S;
      end
      default: c.illegal = 1'b1;
    endcase
    if (c.illegal) begin
      c.use_rs1 = 1'b0;
      c.use_rs2 = 1'b0;
      c.wen_cls = 1'b0;
      c.fmt     = IMM_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/id_pipe_imm_gen.sv
// Combinational RV32 immediate generator (I/S/B/U/J), sign-extended to XLEN.
module id_imm_gen
  import id_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0] imm32;
  logic               unused_opcode;

  assign unused_opcode = ^inst_i[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      IMM_U: imm32 = {inst_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/id_pipe.sv
// Single-stage RV32 instruction decode with one output register, load-use
// stall and flush. Define ID_BYPASS_EN to forward non-load EX results.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [31:0]     inst_i,
  output logic [RA_W-1:0] rs1_addr_o,
  output logic [RA_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            ex_wen_i,
  input  logic [RA_W-1:0] ex_wd_addr_i,
  input  logic            ex_is_load_i,
  input  logic [XLEN-1:0] ex_wd_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] op_1_o,
  output logic [XLEN-1:0] op_2_o,
  output logic [XLEN-1:0] op_3_o,
  output logic [RA_W-1:0] wd_addr_o,
  output logic            reg_wen_o,
  output logic            illegal_o
);

  dec_ctrl_t       ctrl;
  logic [RA_W-1:0] rs1_f, rs2_f, rd_f;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            ex_hit, hazard, accept;

  logic [XLEN-1:0] op1_c, op2_c, op3_c;
  logic            wen_c;
  logic [RA_W-1:0] wd_c;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] inst_addr_d, inst_addr_q;
  logic [31:0]     inst_d, inst_q;
  logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q, op3_d, op3_q;
  logic [RA_W-1:0] wd_addr_d, wd_addr_q;
  logic            reg_wen_d, reg_wen_q;
  logic            illegal_d, illegal_q;

  assign ctrl  = decode_ctrl(inst_i);
  assign rs1_f = RA_W'(inst_i[19:15]);
  assign rs2_f = RA_W'(inst_i[24:20]);
  assign rd_f  = RA_W'(inst_i[11:7]);

  assign rs1_addr_o = ctrl.use_rs1 ? rs1_f : '0;
  assign rs2_addr_o = ctrl.use_rs2 ? rs2_f : '0;

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (inst_i),
    .fmt_i  (ctrl.fmt),
    .imm_o  (imm)
  );

  assign ex_hit = ex_wen_i && (ex_wd_addr_i != '0) &&
                  ((ctrl.use_rs1 && (ex_wd_addr_i == rs1_f)) ||
                   (ctrl.use_rs2 && (ex_wd_addr_i == rs2_f)));

`ifdef ID_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok  = ex_wen_i && !ex_is_load_i && (ex_wd_addr_i != '0);
  assign rs1_val = (fwd_ok && (ex_wd_addr_i == rs1_f)) ? ex_wd_data_i : rs1_data_i;
  assign rs2_val = (fwd_ok && (ex_wd_addr_i == rs2_f)) ? ex_wd_data_i : rs2_data_i;
  // Only a load result is still unavailable; everything else is forwarded.
  assign hazard  = in_valid_i && ex_hit && ex_is_load_i;
`else
  logic unused_ex;
  assign unused_ex = ^{ex_wd_data_i, ex_is_load_i};
  assign rs1_val   = rs1_data_i;
  assign rs2_val   = rs2_data_i;
  assign hazard    = in_valid_i && ex_hit;
`endif

  assign in_ready_o = !rst && (!valid_q || out_ready_i) && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    op1_c = '0;
    op2_c = '0;
    op3_c = '0;
    if (!ctrl.illegal) begin
      case (inst_i[6:0])
        OPC_OP_IMM: begin
          op1_c = rs1_val;
          op2_c = ((inst_i[14:12] == F3_SLL) || (inst_i[14:12] == F3_SRL_SRA)) ?
                  XLEN'(inst_i[24:20]) : imm;
        end
        OPC_OP: begin
          op1_c = rs1_val;
          op2_c = rs2_val;
        end
        OPC_BRANCH: begin
          op1_c = rs1_val;
          op2_c = rs2_val;
          op3_c = imm;
        end
        OPC_LUI: op1_c = imm;
        OPC_AUIPC: begin
          op1_c = inst_addr_i;
          op2_c = imm;
        end
        OPC_JAL: begin
          op1_c = inst_addr_i;
          op2_c = XLEN'(4);
          op3_c = imm;
        end
        OPC_JALR, OPC_LOAD: begin
          op1_c = rs1_val;
          op2_c = imm;
        end
        OPC_STORE: begin
          op1_c = rs1_val;
          op2_c = imm;
          op3_c = rs2_val;
        end
        default: ;
      endcase
    end
  end

  assign wen_c = ctrl.wen_cls && (rd_f != '0);
  assign wd_c  = wen_c ? rd_f : '0;

  // A held result only moves when EX takes it; flush overrides everything.
  always_comb begin
    valid_d     = valid_q;
    inst_addr_d = inst_addr_q;
    inst_d      = inst_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op3_d       = op3_q;
    wd_addr_d   = wd_addr_q;
    reg_wen_d   = reg_wen_q;
    illegal_d   = illegal_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!valid_q || out_ready_i) begin
      valid_d = accept;
      if (accept) begin
        inst_addr_d = inst_addr_i;
        inst_d      = inst_i;
        op1_d       = op1_c;
        op2_d       = op2_c;
        op3_d       = op3_c;
        wd_addr_d   = wd_c;
        reg_wen_d   = wen_c;
        illegal_d   = ctrl.illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      inst_addr_q <= '0;
      inst_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      wd_addr_q   <= '0;
      reg_wen_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      inst_addr_q <= inst_addr_d;
      inst_q      <= inst_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op3_q       <= op3_d;
      wd_addr_q   <= wd_addr_d;
      reg_wen_q   <= reg_wen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid_o = valid_q;
  assign inst_addr_o = inst_addr_q;
  assign inst_o      = inst_q;
  assign op_1_o      = op1_q;
  assign op_2_o      = op2_q;
  assign op_3_o      = op3_q;
  assign wd_addr_o   = wd_addr_q;
  assign reg_wen_o   = reg_wen_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_pipe.sv
// Randomized bench for id_pipe against a behavioural decode/handshake model;
// honours ID_BYPASS_EN the same way the design does.
module tb_id_pipe;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk, rst;
  logic            in_valid_i, in_ready_o;
  logic [31:0]     inst_addr_i, inst_i;
  logic [4:0]      rs1_addr_o, rs2_addr_o;
  logic [31:0]     rs1_data_i, rs2_data_i;
  logic            ex_wen_i, ex_is_load_i;
  logic [4:0]      ex_wd_addr_i;
  logic [31:0]     ex_wd_data_i;
  logic            flush_i, out_valid_o, out_ready_i;
  logic [31:0]     inst_addr_o, inst_o, op_1_o, op_2_o, op_3_o;
  logic [4:0]      wd_addr_o;
  logic            reg_wen_o, illegal_o;

  id_pipe #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_addr_i(inst_addr_i), .inst_i(inst_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .ex_wen_i(ex_wen_i), .ex_wd_addr_i(ex_wd_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_wd_data_i(ex_wd_data_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_addr_o(inst_addr_o), .inst_o(inst_o),
    .op_1_o(op_1_o), .op_2_o(op_2_o), .op_3_o(op_3_o),
    .wd_addr_o(wd_addr_o), .reg_wen_o(reg_wen_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        ill, wen, u1, u2;
    logic [4:0]  wd;
    logic [31:0] op1, op2, op3;
  } exp_t;

  // Reference decode straight from the operand-mapping table.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   imm_i, imm_s, imm_b, imm_u, imm_j;
    int   f3, f7;
    logic legal;
    imm_i = $signed(inst[31:20]);
    imm_s = $signed({inst[31:25], inst[11:7]});
    imm_b = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    imm_u = int'({inst[31:12], 12'b0});
    imm_j = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    e = '{default: '0};
    legal = 1'b1;
    case (inst[6:0])
      7'h13: begin e.u1 = 1; e.wen = 1; e.op1 = a;
                   e.op2 = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : imm_i; end
      7'h33: begin legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                   e.u1 = 1; e.u2 = 1; e.wen = 1; e.op1 = a; e.op2 = b; end
      7'h63: begin legal = (f3 != 2) && (f3 != 3);
                   e.u1 = 1; e.u2 = 1; e.op1 = a; e.op2 = b; e.op3 = imm_b; end
      7'h37: begin e.wen = 1; e.op1 = imm_u; end
      7'h17: begin e.wen = 1; e.op1 = pc; e.op2 = imm_u; end
      7'h6f: begin e.wen = 1; e.op1 = pc; e.op2 = 4; e.op3 = imm_j; end
      7'h67: begin e.u1 = 1; e.wen = 1; e.op1 = a; e.op2 = imm_i; end
      7'h03: begin e.u1 = 1; e.wen = 1; e.op1 = a; e.op2 = imm_i; end
      7'h23: begin e.u1 = 1; e.u2 = 1; e.op1 = a; e.op2 = imm_s; e.op3 = b; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '{default: '0};
      e.ill = 1'b1;
    end
    if (inst[11:7] == 0) e.wen = 1'b0;
    e.wd = e.wen ? inst[11:7] : 5'd0;
    return e;
  endfunction

  // Model of the output register contents.
  logic        m_valid = 0, m_rst = 0;
  exp_t        m_exp;
  logic [31:0] m_inst, m_pc;

  task automatic step();
    exp_t        d;
    logic [31:0] a, b;
    logic [4:0]  r1, r2;
    logic        hz, rdy;
    #1;
    r1 = inst_i[19:15];
    r2 = inst_i[24:20];
    a  = rs1_data_i;
    b  = rs2_data_i;
`ifdef ID_BYPASS_EN
    if (ex_wen_i && !ex_is_load_i && ex_wd_addr_i != 0 && ex_wd_addr_i == r1) a = ex_wd_data_i;
    if (ex_wen_i && !ex_is_load_i && ex_wd_addr_i != 0 && ex_wd_addr_i == r2) b = ex_wd_data_i;
`endif
    d  = ref_decode(inst_i, inst_addr_i, a, b);
    hz = in_valid_i && ex_wen_i && ex_wd_addr_i != 0 &&
         ((d.u1 && ex_wd_addr_i == r1) || (d.u2 && ex_wd_addr_i == r2));
`ifdef ID_BYPASS_EN
    hz = hz && ex_is_load_i;
`endif
    rdy = !rst && (!m_valid || out_ready_i) && !hz && !flush_i;
    check_eq("in_ready", in_ready_o, rdy);
    check_eq("rs1_addr", rs1_addr_o, d.u1 ? r1 : 5'd0);
    check_eq("rs2_addr", rs2_addr_o, d.u2 ? r2 : 5'd0);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_rst = 1; m_exp = '{default: '0}; m_inst = 0; m_pc = 0;
    end else if (flush_i) begin
      m_valid = 0;
    end else if (!m_valid || out_ready_i) begin
      if (in_valid_i && rdy) begin
        m_valid = 1; m_rst = 0; m_exp = d; m_inst = inst_i; m_pc = inst_addr_i;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check_eq("out_valid", out_valid_o, m_valid);
    if (m_valid || m_rst) begin
      check_eq("inst_o", inst_o, m_inst);
      check_eq("inst_addr_o", inst_addr_o, m_pc);
      check_eq("op_1", op_1_o, m_exp.op1);
      check_eq("op_2", op_2_o, m_exp.op2);
      check_eq("op_3", op_3_o, m_exp.op3);
      check_eq("wd_addr", wd_addr_o, m_exp.wd);
      check_eq("reg_wen", reg_wen_o, m_exp.wen);
      check_eq("illegal", illegal_o, m_exp.ill);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opc_tbl [10];
    logic [6:0] f7_tbl [3];
    int         k;
    opc_tbl = '{7'h13, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h00};
    f7_tbl  = '{7'h00, 7'h20, 7'h00};
    f7_tbl[2] = 7'($urandom);
    k = $urandom_range(0, 10);
    if (k == 10) return $urandom;
    return {f7_tbl[$urandom_range(0, 2)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), (k == 9) ? 7'($urandom) : opc_tbl[k]};
  endfunction

  initial begin
    rst = 1; in_valid_i = 0; inst_addr_i = 0; inst_i = 0;
    rs1_data_i = 0; rs2_data_i = 0; ex_wen_i = 0; ex_wd_addr_i = 0;
    ex_is_load_i = 0; ex_wd_data_i = 0; flush_i = 0; out_ready_i = 1;
    @(negedge clk);
    step();
    step();
    check_eq("rst_valid", out_valid_o, 1'b0);
    check_eq("rst_op1", op_1_o, 32'h0);
    rst = 0;

    // addi x1,x2,5
    in_valid_i = 1; inst_i = 32'h00510093; inst_addr_i = 32'h100; rs1_data_i = 32'h10;
    step();
    check_eq("addi_op1", op_1_o, 32'h10);
    check_eq("addi_op2", op_2_o, 32'h5);
    check_eq("addi_wd", wd_addr_o, 5'd1);
    check_eq("addi_wen", reg_wen_o, 1'b1);

    // load-use on x2
    ex_wen_i = 1; ex_is_load_i = 1; ex_wd_addr_i = 2; inst_addr_i = 32'h104;
    step();
    check_eq("lu_bubble", out_valid_o, 1'b0);
    ex_is_load_i = 0; ex_wen_i = 0;
    step();
    check_eq("lu_accept", out_valid_o, 1'b1);

    // EX-stage result on x2, non-load
    ex_wen_i = 1; ex_wd_addr_i = 2; ex_wd_data_i = 32'h1234; rs1_data_i = 0; inst_addr_i = 32'h108;
    step();
`ifdef ID_BYPASS_EN
    check_eq("byp_op1", op_1_o, 32'h1234);
`else
    check_eq("byp_stall", out_valid_o, 1'b0);
`endif
    ex_wen_i = 0;
    step();

    inst_i = 32'hFFFFFFFF; inst_addr_i = 32'h10c;
    step();
    check_eq("ill_flag", illegal_o, 1'b1);
    check_eq("ill_wen", reg_wen_o, 1'b0);
    check_eq("ill_valid", out_valid_o, 1'b1);

    // backpressure with flush on the second stalled cycle
    inst_i = 32'h00708193; inst_addr_i = 32'h110; rs1_data_i = 32'h77;
    step();
    out_ready_i = 0; inst_i = 32'h00310133; inst_addr_i = 32'h114;
    step();
    check_eq("bp_hold_op1", op_1_o, 32'h77);
    flush_i = 1;
    step();
    check_eq("bp_flush", out_valid_o, 1'b0);
    flush_i = 0;
    step();

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      in_valid_i   = ($urandom_range(0, 3) != 0);
      out_ready_i  = ($urandom_range(0, 3) != 0);
      inst_i       = rand_inst();
      inst_addr_i  = $urandom & 32'hFFFF_FFFC;
      rs1_data_i   = $urandom;
      rs2_data_i   = $urandom;
      ex_wen_i     = 1'($urandom);
      ex_is_load_i = 1'($urandom);
      ex_wd_addr_i = 5'($urandom_range(0, 3));
      ex_wd_data_i = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, datapath width; RV32 encodings are sign-extended to XLEN.
- RA_W, 5, register address width.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  fetch presents an instruction.
- in_ready_o  out  1  id_pipe accepts the instruction this cycle.
- inst_addr_i  in  XLEN  PC of the instruction.
- inst_i  in  32  instruction word.
- rs1_addr_o / rs2_addr_o  out  RA_W  combinational register-file read addresses.
- rs1_data_i / rs2_data_i  in  XLEN  register-file read data, same cycle.
- ex_wen_i  in  1  EX-stage instruction writes a register.
- ex_wd_addr_i  in  RA_W  EX-stage destination register.
- ex_is_load_i  in  1  EX-stage instruction is a load.
- ex_wd_data_i  in  XLEN  EX-stage result, used only under ID_BYPASS_EN.
- flush_i  in  1  kill the held and incoming instruction.
- out_valid_o  out  1  registered decode result is valid.
- out_ready_i  in  1  EX accepts the result.
- inst_addr_o, inst_o, op_1_o, op_2_o, op_3_o  out  XLEN/32/XLEN/XLEN/XLEN  registered outputs.
- wd_addr_o  out  RA_W  registered destination register.
- reg_wen_o  out  1  registered write enable.
- illegal_o  out  1  registered illegal-instruction flag.

Function
REQ-003 Decode is combinational; its result is captured into one output register; latency is 1 cycle from accept to out_valid_o.
REQ-004 Transfer rules: an input transfer is in_valid_i && in_ready_o; an output transfer is out_valid_o && out_ready_i.
REQ-005 Ready rule: in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i.
REQ-006 Hazard = ex_is_load_i && ex_wen_i && ex_wd_addr_i != 0 && ex_wd_addr_i matches a source the instruction actually uses (rs1, rs2 or both).
- When hazard is true and the register is free, a bubble is loaded: out_valid_o = 0.
REQ-007 While out_valid_o && !out_ready_i, all outputs stay bit-stable.
REQ-008 flush_i has priority over every other event: next cycle out_valid_o = 0 and nothing is accepted.
REQ-009 Operand mapping per opcode:
- OP-IMM: op1 = rs1, op2 = I-imm; SLLI/SRLI/SRAI take op2 = zero-extended shamt.
- OP: op1 = rs1, op2 = rs2.
- BRANCH: op1 = rs1, op2 = rs2, op3 = B-imm.
- LUI: op1 = U-imm, op2 = 0.
- AUIPC: op1 = PC, op2 = U-imm.
- JAL: op1 = PC, op2 = 4, op3 = J-imm.
- JALR: op1 = rs1, op2 = I-imm.
- LOAD: op1 = rs1, op2 = I-imm.
- STORE: op1 = rs1, op2 = S-imm, op3 = rs2.
- Unused op fields and unused read addresses are 0.
REQ-010 reg_wen_o = 1 for OP-IMM, OP, LUI, AUIPC, JAL, JALR and LOAD, except that rd = 0 forces reg_wen_o = 0; wd_addr_o = 0 whenever reg_wen_o = 0.
REQ-011 Illegal instructions set illegal_o = 1, reg_wen_o = 0 and all ops = 0, and still pass with out_valid_o = 1. Illegal means:
- an unknown opcode;
- a BRANCH with funct3 010 or 011;
- an OP with funct7 other than 0000000, or 0100000 limited to ADD/SUB and SRL/SRA.
REQ-012 inst_addr_o and inst_o are registered copies of inst_addr_i and inst_i.

Reset
REQ-013 While rst is high at a clock edge, next cycle all outputs are 0: out_valid_o, illegal_o, reg_wen_o, wd_addr_o, op_1_o, op_2_o, op_3_o, inst_o and inst_addr_o.
- in_ready_o is also 0 during reset.
- Reset mid-transfer discards the held instruction.

Configuration
REQ-014 Macro ID_BYPASS_EN selects EX-stage forwarding.
- Defined: when ex_wen_i && !ex_is_load_i && ex_wd_addr_i != 0 && ex_wd_addr_i == rsN, the rsN operand is taken from ex_wd_data_i instead of rsN_data_i.
- Undefined: operands always come from the register file, and any ex_wen_i match on a used source also raises hazard.

Structure
REQ-015 A shared package holds opcode and funct3/funct7 constants and the immediate-format enumeration.
REQ-016 One sub-module, id_imm_gen, SHALL produce the I/S/B/U/J immediates from inst_i and the format select; it is combinational.

Verification
REQ-017 addi x1,x2,5 (0x00510093), rs1_data_i = 0x10 -> next cycle op1 = 0x10, op2 = 5, wd_addr_o = 1, reg_wen_o = 1, out_valid_o = 1.
REQ-018 Load-use: ex_is_load_i = 1, ex_wen_i = 1, ex_wd_addr_i = 2 with addi reading x2 -> in_ready_o = 0 and a bubble is inserted; accepted the cycle after ex_is_load_i drops.
REQ-019 Bypass, macro defined: ex_wen_i = 1, ex_wd_addr_i = 2, ex_wd_data_i = 0x1234, rs1_data_i = 0 -> op1 = 0x1234. Macro undefined -> stall as in REQ-018.
REQ-020 inst_i = 0xFFFFFFFF -> illegal_o = 1, reg_wen_o = 0, out_valid_o = 1.
REQ-021 Backpressure: out_ready_i = 0 for 3 cycles -> outputs held stable and in_ready_o = 0; flush_i on the 2nd cycle -> out_valid_o = 0 on the next cycle.
